status_grid_arbiter: RTL and testbench

// - Owns a registered NUM_GROUPS x NUM_LANES grid of status_t {a, b} entries.
// - Shares a single write port to that grid among NUM_GROUPS*NUM_LANES requesters.
// - Arbitration is round-robin: at most one entry is updated per cycle.
// - Adds a sequenced CLEAR operation that walks the grid and restores every entry to RESET_STATUS.
// - Sits between per-lane status producers and the consumers that read status_out[g][l].

---
 rtl/status_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/status_grid_arbiter.sv | 134 +++++++++++++
 tb/tb_status_grid_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_pkg.sv
// Shared types for the status grid arbiter.
// Status entry layout, reset value and FSM state encoding.
package status_pkg;

  typedef struct packed {
    logic a;
    logic b;
  } status_t;

  localparam status_t RESET_STATUS = '{a: 1'b1, b: 1'b0};

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr and picks the first valid entry.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] j;

  // Rotating priority scan from ptr, wrapping modulo N.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) begin
        j = j - (IW+1)'(N);
      end
      if (!any && req[j[IW-1:0]]) begin
        any = 1'b1;
        idx = j[IW-1:0];
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/status_grid_arbiter.sv
// Registered status grid with one shared write port.
// Round-robin requester arbitration plus a sequenced grid clear.
module status_grid_arbiter
  import status_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int NUM_LANES  = 2,
  localparam int N  = NUM_GROUPS * NUM_LANES,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_GROUPS-1:0][NUM_LANES-1:0] req_valid,
  input  status_t [NUM_GROUPS-1:0][NUM_LANES-1:0] req_status,
  output logic [NUM_GROUPS-1:0][NUM_LANES-1:0] req_ready,
  input  logic                                 clr_req,
  output logic                                 busy,
  output logic                                 clr_done,
  output status_t [NUM_GROUPS-1:0][NUM_LANES-1:0] status_out,
  output logic                                 upd_valid,
  output logic [IW-1:0]                        upd_idx
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cidx_q, cidx_d;
  logic            clr_done_q, clr_done_d;
  logic            upd_valid_q, upd_valid_d;
  logic [IW-1:0]   upd_idx_q, upd_idx_d;
  status_t [N-1:0] grid_q;

  logic [N-1:0]    req_flat;
  status_t [N-1:0] stat_flat;
  logic [N-1:0]    gnt_flat;
  logic [N-1:0]    rdy_flat;
  logic [IW-1:0]   win;
  logic            any;
  logic            grant_en;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam int I = g * NUM_LANES + l;
      assign req_flat[I]     = req_valid[g][l];
      assign stat_flat[I]    = req_status[g][l];
      assign req_ready[g][l] = rdy_flat[I];
      assign status_out[g][l] = grid_q[I];
    end
  end

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req (req_flat),
    .ptr (ptr_q),
    .gnt (gnt_flat),
    .idx (win),
    .any (any)
  );

  assign rdy_flat  = gnt_flat & {N{grant_en}};
  assign busy      = (state_q == CLEAR);
  assign clr_done  = clr_done_q;
  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;

  // Next-state logic: arbitration in RUN, index walk in CLEAR.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cidx_d      = cidx_q;
    clr_done_d  = 1'b0;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    grant_en    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
          cidx_d  = '0;
        end else if (any) begin
          grant_en    = 1'b1;
          ptr_d       = (win == IW'(N-1)) ? '0 : win + 1'b1;
          upd_valid_d = 1'b1;
          upd_idx_d   = win;
        end
      end
      CLEAR: begin
        if (cidx_q == IW'(N-1)) begin
          state_d    = RUN;
          cidx_d     = '0;
          ptr_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cidx_d = cidx_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      cidx_q      <= '0;
      clr_done_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cidx_q      <= cidx_d;
      clr_done_q  <= clr_done_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
    end
  end

  // Grid storage: winner write in RUN, reset-value write in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        grid_q[i] <= RESET_STATUS;
      end
    end else if (state_q == CLEAR) begin
      grid_q[cidx_q] <= RESET_STATUS;
    end else if (grant_en) begin
      grid_q[win] <= stat_flat[win];
    end
  end

endmodule

// File: tb/tb_status_grid_arbiter.sv
// Directed testbench for status_grid_arbiter.
// Covers a 2x2 instance and a 1x1 instance.
module tb_status_grid_arbiter;
  import status_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0][1:0]    rv;
  status_t [1:0][1:0] rs;
  logic [1:0][1:0]    rr;
  logic               clr;
  logic               busy;
  logic               cdone;
  status_t [1:0][1:0] so;
  logic               uv;
  logic [1:0]         ui;

  logic [0:0][0:0]    rv1;
  status_t [0:0][0:0] rs1;
  logic [0:0][0:0]    rr1;
  logic               clr1;
  logic               busy1;
  logic               cdone1;
  status_t [0:0][0:0] so1;
  logic               uv1;
  logic [0:0]         ui1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  status_grid_arbiter #(.NUM_GROUPS(2), .NUM_LANES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_status(rs), .req_ready(rr),
    .clr_req(clr), .busy(busy), .clr_done(cdone),
    .status_out(so), .upd_valid(uv), .upd_idx(ui)
  );

  status_grid_arbiter #(.NUM_GROUPS(1), .NUM_LANES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_status(rs1), .req_ready(rr1),
    .clr_req(clr1), .busy(busy1), .clr_done(cdone1),
    .status_out(so1), .upd_valid(uv1), .upd_idx(ui1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    tests++;
    if (so !== 8'b10101010) begin
      fails++;
      $display("FAIL reset_status got %b want 10101010", so);
    end
    tests++;
    if ({busy, cdone, uv, ui} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, cdone, uv, ui});
    end
    tests++;
    if ({so1, busy1, cdone1, uv1} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_n1 got %b want 10000", {so1, busy1, cdone1, uv1});
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single;
    rv = 4'b0100;
    rs[1][0] = 2'b01;
    #1;
    tests++;
    if (rr !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready got %b want 0100", rr);
    end
    tick();
    rv = 4'b0000;
    tests++;
    if (so[1][0] !== 2'b01 || uv !== 1'b1 || ui !== 2'd2) begin
      fails++;
      $display("FAIL single_write got so=%b uv=%b ui=%0d want 01 1 2",
               so[1][0], uv, ui);
    end
    tick();
    tests++;
    if (uv !== 1'b0) begin
      fails++;
      $display("FAIL single_uv_drop got %b want 0", uv);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] want;
    do_reset();
    rs = 8'b01_00_11_01;
    rv = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      want = 4'b0001 << (k % 4);
      #1;
      tests++;
      if (rr !== want) begin
        fails++;
        $display("FAIL fair_ready[%0d] got %b want %b", k, rr, want);
      end
      tick();
      tests++;
      if (uv !== 1'b1 || ui !== 2'(k % 4)) begin
        fails++;
        $display("FAIL fair_upd[%0d] got uv=%b ui=%0d want 1 %0d",
                 k, uv, ui, k % 4);
      end
    end
    rv = 4'b0000;
    tests++;
    if (so !== 8'b01001101) begin
      fails++;
      $display("FAIL fair_grid got %b want 01001101", so);
    end
  endtask

  task automatic test_collision;
    logic [7:0] exp;
    exp = 8'b01001101;
    clr = 1'b1;
    rv = 4'b0010;
    #1;
    tests++;
    if (rr !== 4'b0000) begin
      fails++;
      $display("FAIL coll_ready got %b want 0000", rr);
    end
    tick();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (busy !== 1'b1 || rr !== 4'b0000 || cdone !== 1'b0) begin
        fails++;
        $display("FAIL coll_clear[%0d] got busy=%b rr=%b done=%b want 1 0000 0",
                 k, busy, rr, cdone);
      end
      tick();
      exp[2*k +: 2] = 2'b10;
      tests++;
      if (so !== exp) begin
        fails++;
        $display("FAIL coll_grid[%0d] got %b want %b", k, so, exp);
      end
    end
    tests++;
    if (cdone !== 1'b1 || busy !== 1'b0 || rr !== 4'b0010) begin
      fails++;
      $display("FAIL coll_done got done=%b busy=%b rr=%b want 1 0 0010",
               cdone, busy, rr);
    end
    tick();
    rv = 4'b0000;
    exp[3:2] = 2'b11;
    tests++;
    if (cdone !== 1'b0 || uv !== 1'b1 || ui !== 2'd1 || so !== exp) begin
      fails++;
      $display("FAIL coll_grant got done=%b uv=%b ui=%0d so=%b want 0 1 1 %b",
               cdone, uv, ui, so, exp);
    end
  endtask

  task automatic test_reset_mid_clear;
    rv = 4'b0001;
    tick();
    rv = 4'b0000;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || cdone !== 1'b0 || so !== 8'b10101010) begin
      fails++;
      $display("FAIL mid_rst got busy=%b done=%b so=%b want 0 0 10101010",
               busy, cdone, so);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (cdone !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_nodone[%0d] got done=%b busy=%b want 0 0",
                 k, cdone, busy);
      end
    end
    rv = 4'b1111;
    #1;
    tests++;
    if (rr !== 4'b0001) begin
      fails++;
      $display("FAIL mid_ptr got %b want 0001", rr);
    end
    rv = 4'b0000;
    #1;
  endtask

  task automatic test_back_to_back;
    clr = 1'b1;
    rv = 4'b1000;
    tick();
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (cdone !== 1'b1 || busy !== 1'b0 || rr !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_done got done=%b busy=%b rr=%b want 1 0 0000",
               cdone, busy, rr);
    end
    tick();
    clr = 1'b0;
    tests++;
    if (busy !== 1'b1 || cdone !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, cdone);
    end
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (cdone !== 1'b1 || busy !== 1'b0 || rr !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_grant got done=%b busy=%b rr=%b want 1 0 1000",
               cdone, busy, rr);
    end
    tick();
    rv = 4'b0000;
  endtask

  task automatic test_n1;
    logic [1:0] v;
    rv1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = (k % 2 == 0) ? 2'b01 : 2'b11;
      rs1 = v;
      #1;
      tests++;
      if (rr1 !== 1'b1) begin
        fails++;
        $display("FAIL n1_ready[%0d] got %b want 1", k, rr1);
      end
      tick();
      tests++;
      if (uv1 !== 1'b1 || ui1 !== 1'b0 || so1 !== v) begin
        fails++;
        $display("FAIL n1_write[%0d] got uv=%b ui=%b so=%b want 1 0 %b",
                 k, uv1, ui1, so1, v);
      end
    end
    rv1 = 1'b0;
    clr1 = 1'b1;
    #1;
    tests++;
    if (rr1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_clr_ready got %b want 0", rr1);
    end
    tick();
    clr1 = 1'b0;
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL n1_busy got %b want 1", busy1);
    end
    tick();
    tests++;
    if (busy1 !== 1'b0 || cdone1 !== 1'b1 || so1 !== 2'b10) begin
      fails++;
      $display("FAIL n1_done got busy=%b done=%b so=%b want 0 1 10",
               busy1, cdone1, so1);
    end
  endtask

  initial begin
    rv   = '0;
    rs   = '0;
    clr  = 1'b0;
    rv1  = '0;
    rs1  = '0;
    clr1 = 1'b0;
    #2;
    test_reset();
    test_single();
    test_fairness();
    test_collision();
    test_reset_mid_clear();
    test_back_to_back();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
